// File: rtl/g_tcam_array_if.sv
// Search/write/result bundle for the ternary CAM array.
// The master side drives writes and search requests; the slave side returns results.
interface g_tcam_array_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clr_all;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_key;
    logic [WIDTH-1:0]  wr_mask;
    logic              wr_vld;
    logic              srch_vld;
    logic [WIDTH-1:0]  srch_key;
    logic              rslt_vld;
    logic              rslt_hit;
    logic [ADDR_W-1:0] rslt_addr;
    logic              rslt_multi;
    logic [ADDR_W:0]   rslt_cnt;

    modport master (
        output clr_all, wr_en, wr_addr, wr_key, wr_mask, wr_vld, srch_vld, srch_key,
        input  rslt_vld, rslt_hit, rslt_addr, rslt_multi, rslt_cnt
    );

    modport slave (
        input  clr_all, wr_en, wr_addr, wr_key, wr_mask, wr_vld, srch_vld, srch_key,
        output rslt_vld, rslt_hit, rslt_addr, rslt_multi, rslt_cnt
    );
endinterface

// File: rtl/g_tcam_array.sv
// Ternary CAM array: DEPTH x WIDTH entries with per-bit don't-care masks and a
// two-stage search pipeline (match vector, then lowest-index encode and popcount).
module g_tcam_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input logic           clk,
    input logic           rst,
    g_tcam_array_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  key_q  [DEPTH];
    logic [WIDTH-1:0]  mask_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  match_c;
    logic [DEPTH-1:0]  match_q;
    logic              s1_vld_q;

    logic              enc_hit;
    logic [ADDR_W-1:0] enc_addr;
    logic [CNT_W-1:0]  enc_cnt;

    logic              rslt_vld_q;
    logic              rslt_hit_q;
    logic [ADDR_W-1:0] rslt_addr_q;
    logic              rslt_multi_q;
    logic [CNT_W-1:0]  rslt_cnt_q;

    // Out-of-range write addresses never equal any index, so they drop out naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i]  <= '0;
                mask_q[i] <= '0;
            end
        end else if (bus.clr_all) begin
            vld_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
                    key_q[i]  <= bus.wr_key;
                    mask_q[i] <= bus.wr_mask;
                    vld_q[i]  <= bus.wr_vld;
                end
            end
        end
    end

    always_comb begin
        match_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_c[i] = vld_q[i] && (((bus.srch_key ^ key_q[i]) & ~mask_q[i]) == '0);
        end
    end

    // Idle cycles load an all-zero vector so stage 2 naturally yields zero results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            match_q  <= '0;
        end else begin
            s1_vld_q <= bus.srch_vld;
            match_q  <= bus.srch_vld ? match_c : '0;
        end
    end

    always_comb begin
        enc_hit  = |match_q;
        enc_addr = '0;
        enc_cnt  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                enc_addr = ADDR_W'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            enc_cnt = enc_cnt + CNT_W'(match_q[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rslt_vld_q   <= 1'b0;
            rslt_hit_q   <= 1'b0;
            rslt_addr_q  <= '0;
            rslt_multi_q <= 1'b0;
            rslt_cnt_q   <= '0;
        end else begin
            rslt_vld_q   <= s1_vld_q;
            rslt_hit_q   <= enc_hit;
            rslt_addr_q  <= enc_addr;
            rslt_multi_q <= (enc_cnt >= CNT_W'(2));
            rslt_cnt_q   <= enc_cnt;
        end
    end

    assign bus.rslt_vld   = rslt_vld_q;
    assign bus.rslt_hit   = rslt_hit_q;
    assign bus.rslt_addr  = rslt_addr_q;
    assign bus.rslt_multi = rslt_multi_q;
    assign bus.rslt_cnt   = rslt_cnt_q;
endmodule

// File: tb/tb_g_tcam_array.sv
// Bench for g_tcam_array: directed scenarios with literal expectations plus a
// randomized phase, all outputs checked every cycle against a behavioural model.
module tb_g_tcam_array;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic        vld;
        logic        hit;
        logic [3:0]  addr;
        logic        multi;
        logic [4:0]  cnt;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;

    g_tcam_array_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    g_tcam_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] m_key  [DEPTH];
    logic [WIDTH-1:0] m_mask [DEPTH];
    logic             m_vld  [DEPTH];
    res_t             exp1 = '0;
    res_t             exp2 = '0;

    function automatic res_t model_search(logic v, logic [WIDTH-1:0] k);
        res_t r;
        r = '0;
        if (v) begin
            r.vld = 1'b1;
            for (int e = 0; e < DEPTH; e++) begin
                bit ok;
                ok = m_vld[e];
                for (int b = 0; b < WIDTH; b++) begin
                    if (!m_mask[e][b] && (k[b] != m_key[e][b])) ok = 1'b0;
                end
                if (ok) begin
                    if (r.cnt == 0) r.addr = 4'(e);
                    r.cnt = r.cnt + 1;
                end
            end
            r.hit   = (r.cnt != 0);
            r.multi = (r.cnt >= 2);
        end
        return r;
    endfunction

    initial begin
        for (int e = 0; e < DEPTH; e++) begin
            m_key[e] = '0; m_mask[e] = '0; m_vld[e] = 1'b0;
        end
    end

    // Reference: search sees pre-edge contents, then this edge's write/clear lands.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                m_key[e] = '0; m_mask[e] = '0; m_vld[e] = 1'b0;
            end
            exp1 = '0;
            exp2 = '0;
        end else begin
            exp2 = exp1;
            exp1 = model_search(bus.srch_vld, bus.srch_key);
            if (bus.clr_all) begin
                for (int e = 0; e < DEPTH; e++) m_vld[e] = 1'b0;
            end else if (bus.wr_en && (int'(bus.wr_addr) < DEPTH)) begin
                m_key[bus.wr_addr]  = bus.wr_key;
                m_mask[bus.wr_addr] = bus.wr_mask;
                m_vld[bus.wr_addr]  = bus.wr_vld;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_vld",   32'(bus.rslt_vld),   32'(exp2.vld));
            chk("cyc_hit",   32'(bus.rslt_hit),   32'(exp2.hit));
            chk("cyc_addr",  32'(bus.rslt_addr),  32'(exp2.addr));
            chk("cyc_multi", 32'(bus.rslt_multi), 32'(exp2.multi));
            chk("cyc_cnt",   32'(bus.rslt_cnt),   32'(exp2.cnt));
        end
    end

    task automatic clear_strobes();
        bus.clr_all  = 1'b0;
        bus.wr_en    = 1'b0;
        bus.srch_vld = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic set_write(input int a, input logic [31:0] k, input logic [31:0] m, input logic v);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_key  = k;
        bus.wr_mask = m;
        bus.wr_vld  = v;
    endtask

    task automatic set_search(input logic [31:0] k);
        bus.srch_vld = 1'b1;
        bus.srch_key = k;
    endtask

    task automatic expect_res(input string name, input logic v, input logic h,
                              input int a, input int c, input logic mu);
        chk({name, "_vld"},   32'(bus.rslt_vld),   32'(v));
        chk({name, "_hit"},   32'(bus.rslt_hit),   32'(h));
        chk({name, "_addr"},  32'(bus.rslt_addr),  32'(a));
        chk({name, "_cnt"},   32'(bus.rslt_cnt),   32'(c));
        chk({name, "_multi"}, 32'(bus.rslt_multi), 32'(mu));
    endtask

    // Issues one search, then waits until its result is on the outputs.
    task automatic search_and_wait(input logic [31:0] k);
        set_search(k);
        step();
        step();
    endtask

    initial begin
        clear_strobes();
        bus.wr_addr  = '0;
        bus.wr_key   = '0;
        bus.wr_mask  = '0;
        bus.wr_vld   = 1'b0;
        bus.srch_key = '0;

        repeat (2) @(posedge clk);
        #1;
        expect_res("reset", 1'b0, 1'b0, 0, 0, 1'b0);
        chk_en = 1'b1;
        rst = 1'b0;

        search_and_wait(32'hDEADBEEF);
        expect_res("empty", 1'b1, 1'b0, 0, 0, 1'b0);

        set_write(3, 32'h12340000, 32'h0000FFFF, 1'b1);
        step();
        search_and_wait(32'h1234ABCD);
        expect_res("mask_hit", 1'b1, 1'b1, 3, 1, 1'b0);
        search_and_wait(32'h1235ABCD);
        expect_res("mask_miss", 1'b1, 1'b0, 0, 0, 1'b0);

        set_write(2, 32'hA5A5A5A5, 32'h00000000, 1'b1); step();
        set_write(5, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); step();
        set_write(9, 32'hA5A5A500, 32'h000000FF, 1'b1); step();
        search_and_wait(32'hA5A5A5A5);
        expect_res("multi3", 1'b1, 1'b1, 2, 3, 1'b1);
        set_write(2, 32'hA5A5A5A5, 32'h00000000, 1'b0); step();
        search_and_wait(32'hA5A5A5A5);
        expect_res("multi2", 1'b1, 1'b1, 5, 2, 1'b1);

        // Entry 5 matches everything; drop it so the next checks see single hits.
        set_write(5, 32'h0, 32'h0, 1'b0); step();
        set_write(7, 32'h77777777, 32'h0, 1'b1);
        set_search(32'h77777777);
        step();
        set_search(32'h77777777);
        step();
        expect_res("wr_same_cyc", 1'b1, 1'b0, 0, 0, 1'b0);
        step();
        expect_res("wr_next_cyc", 1'b1, 1'b1, 7, 1, 1'b0);

        bus.clr_all = 1'b1;
        set_write(1, 32'h11111111, 32'h0, 1'b1);
        step();
        search_and_wait(32'h11111111);
        expect_res("clr_vs_wr", 1'b1, 1'b0, 0, 0, 1'b0);
        search_and_wait(32'h77777777);
        expect_res("clr_all", 1'b1, 1'b0, 0, 0, 1'b0);

        set_write(4, 32'hC0DE0000, 32'h0, 1'b1); step();
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) set_search((i % 2 == 0) ? 32'hC0DE0000 : 32'hC0DE0001);
            step();
            if (i >= 1) begin
                if ((i - 1) % 2 == 0) expect_res("stream_hit", 1'b1, 1'b1, 4, 1, 1'b0);
                else                  expect_res("stream_miss", 1'b1, 1'b0, 0, 0, 1'b0);
            end
        end

        set_search(32'hC0DE0000);
        step();
        set_search(32'hC0DE0000);
        rst = 1'b1;
        step();
        step();
        expect_res("rst_mid", 1'b0, 1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        step();
        expect_res("rst_after1", 1'b0, 1'b0, 0, 0, 1'b0);
        step();
        expect_res("rst_after2", 1'b0, 1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            bus.clr_all = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 2) == 0) begin
                set_write(int'($urandom_range(0, DEPTH - 1)),
                          32'h5A000000 | ($urandom & 32'hF),
                          ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFF :
                          (($urandom_range(0, 3) == 0) ? 32'h3 : 32'h0),
                          ($urandom_range(0, 4) != 0));
            end
            if ($urandom_range(0, 3) != 0) set_search(32'h5A000000 | ($urandom & 32'hF));
            step();
        end
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/g_tcam_array.md
Name: g_tcam_array

Overview:
- Parametrised ternary CAM array. Generalises the single-bit ternary cell to DEPTH entries of WIDTH bits, each with a per-bit don't-care mask and an entry valid flag.
- Adds a two-stage pipelined search with a lowest-index priority encoder, multi-hit flag and hit count.
- Adds single-cycle clear-all.
- Sits in the FF-based CAM family as the lookup core behind packet or flow classifiers.

Parameters:
- WIDTH, 32: key and entry width in bits (>=1).
- DEPTH, 16: number of entries (>=2).
- ADDR_W, $clog2(DEPTH): entry index width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- clr_all  in  1  invalidate every entry this cycle.
- wr_en  in  1  write strobe for entry wr_addr.
- wr_addr  in  ADDR_W  target entry index.
- wr_key  in  WIDTH  stored value.
- wr_mask  in  WIDTH  per-bit don't-care; 1 = bit ignored.
- wr_vld  in  1  valid flag written with the entry; 0 deletes the entry.
- srch_vld  in  1  search request strobe.
- srch_key  in  WIDTH  search key.
- rslt_vld  out  1  result strobe.
- rslt_hit  out  1  at least one valid entry matched.
- rslt_addr  out  ADDR_W  lowest matching index; 0 when no hit.
- rslt_multi  out  1  two or more entries matched.
- rslt_cnt  out  ADDR_W+1  number of matching entries.

Behaviour:
- Storage: per entry key[WIDTH], mask[WIDTH], vld.
  - On async rst: all fields 0, so every entry is invalid.
- Writes, at the rising edge:
  - If clr_all=1: every vld goes to 0. Key and mask are unchanged. Any wr_en in the same cycle is ignored.
  - Else if wr_en=1 and wr_addr<DEPTH: key, mask and vld of that entry are loaded.
  - wr_addr>=DEPTH (non-power-of-2 DEPTH): the write is dropped silently.
- Match rule:
  - Bit i matches when srch_key[i]==key[i] or mask[i]=1.
  - Entry matches when vld=1 and all WIDTH bits match.
  - All-ones mask with vld=1 matches any key.
- Pipeline: fully pipelined, one search accepted per cycle, no backpressure, no stall.
  - Stage 1 (edge ending cycle T): register the DEPTH-bit match vector and srch_vld. The compare uses entry contents as they are during cycle T, i.e. before any write or clear taking effect at that edge.
  - Stage 2 (edge ending T+1): register the priority-encoder and popcount outputs.
  - Latency: a request in cycle T gives rslt_vld=1 in cycle T+2.
- Result fields:
  - rslt_hit = OR of the match vector.
  - rslt_addr = lowest set index of the match vector, or 0 if none.
  - rslt_cnt = popcount of the match vector, range 0..DEPTH.
  - rslt_multi = (rslt_cnt>=2).
- When rslt_vld=0, all result outputs are driven 0. They are not held.
- Reset values: all outputs 0. Both pipeline stages are cleared.
  - Reset asserted mid-search discards in-flight searches; no rslt_vld appears for them.
- Back-to-back searches with different keys produce results in consecutive cycles, in order.
- A write to entry k in cycle T affects searches issued in T+1 and later only.

Test Plan:
- Reset, then search key 0xDEADBEEF. Required: rslt_vld in cycle 2 with hit=0, addr=0, cnt=0, multi=0.
- Write entry 3 = key 0x12340000, mask 0x0000FFFF, vld=1; search 0x1234ABCD. Required: hit=1, addr=3, cnt=1, multi=0. Search 0x1235ABCD: hit=0.
- Entries 2, 5 and 9 all match key 0xA5A5A5A5. Required: addr=2, cnt=3, multi=1. Rewrite entry 2 with wr_vld=0, then search: addr=5, cnt=2.
- Write entry 7 and search the new key in the same cycle. Required: result reflects the old contents (miss). The same search one cycle later hits at addr 7.
- Assert clr_all together with wr_en to entry 1. Required: next search for that key misses, cnt=0.
- Stream 8 consecutive searches with alternating hit/miss keys. Required: 8 in-order results on consecutive cycles starting at cycle +2. Asserting rst mid-stream yields no further rslt_vld and all outputs 0.
